memory_stream_reader: RTL and testbench

//  Read-side sequencer for the 16x8 sample memory (memory_out). On start, reads COUNT

---
 rtl/memory_stream_reader_pkg.sv | 24 ++
 rtl/memory_stream_reader_stream_fifo2.sv | 72 +++++++
 rtl/memory_stream_reader.sv | 129 ++++++++++++
 tb/tb_memory_stream_reader.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/memory_stream_reader_pkg.sv
// Shared definitions for the memory stream reader.
//  - Geometry of the 16x8 sample memory (DATA_W, ADDR_W, DEPTH).
//  - CNT_W: width of a word count that can express 0..DEPTH.
//  - state_e: sequencer FSM states.
//  - sat_count(): clamps a requested burst length to DEPTH.
package memory_stream_reader_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;
  localparam int CNT_W  = ADDR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_e;

  // A burst longer than the memory would re-read words; clamp it to one pass.
  function automatic logic [CNT_W-1:0] sat_count(input logic [CNT_W-1:0] c);
    return (c > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : c;
  endfunction

endpackage

// File: rtl/memory_stream_reader_stream_fifo2.sv
// stream_fifo2: two-entry register FIFO.
//  Ports:
//   clk, rst        clock, synchronous active-high reset (clears entries too)
//   push, push_data write side; caller never pushes into a full FIFO
//   pop             consume head; ignored while empty
//   head_data       oldest entry (entry 0)
//   head_valid      FIFO holds at least one entry
//   occupancy       number of entries held, 0..2
//  A simultaneous push and pop keeps occupancy and preserves order.
module stream_fifo2 #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic              head_valid,
  output logic [1:0]        occupancy
);

  logic [DATA_W-1:0] e0_q, e0_d;
  logic [DATA_W-1:0] e1_q, e1_d;
  logic [1:0]        occ_q, occ_d;
  logic              pop_ok;

  assign pop_ok     = pop && (occ_q != 2'd0);
  assign head_data  = e0_q;
  assign head_valid = (occ_q != 2'd0);
  assign occupancy  = occ_q;

  always_comb begin
    e0_d  = e0_q;
    e1_d  = e1_q;
    occ_d = occ_q;
    unique case ({push, pop_ok})
      2'b10: begin
        if (occ_q == 2'd0) e0_d = push_data;
        else               e1_d = push_data;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        e0_d  = e1_q;
        occ_d = occ_q - 2'd1;
      end
      2'b11: begin
        // Head leaves while the new word lands behind whatever remains.
        if (occ_q == 2'd1) begin
          e0_d = push_data;
        end else begin
          e0_d = e1_q;
          e1_d = push_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      e0_q  <= '0;
      e1_q  <= '0;
      occ_q <= 2'd0;
    end else begin
      e0_q  <= e0_d;
      e1_q  <= e1_d;
      occ_q <= occ_d;
    end
  end

endmodule

// File: rtl/memory_stream_reader.sv
// memory_stream_reader: read-side sequencer for the 16x8 sample memory.
//  On start, reads count words (clamped to 16) from base_addr upward, wrapping
//  mod 16, and emits them in order as a valid/ready stream.
//  Ports:
//   clk, rst             clock, synchronous active-high reset
//   start                1-cycle launch pulse, ignored unless idle
//   base_addr, count     burst parameters, sampled on start
//   mem_addr, mem_wr     memory address / write enable (write never asserted)
//   mem_data             memory read data, one clock after mem_addr
//   out_data, out_valid  stream output
//   out_ready            stream backpressure
//   busy                 burst in progress
//   done                 one-cycle pulse after the last word is accepted
//  A read is issued only while buffered + in-flight words < 2, so the two-entry
//  buffer can never overflow. While the buffer is empty the in-flight word is
//  presented straight from mem_data, giving one word per clock with no bubble.
module memory_stream_reader
  import memory_stream_reader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  count,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  issue_left_q, issue_left_d;
  logic [CNT_W-1:0]  out_left_q, out_left_d;
  logic              inflight_q, inflight_d;
  logic [ADDR_W-1:0] last_addr_q, last_addr_d;

  logic [DATA_W-1:0] fifo_head;
  logic              fifo_valid;
  logic [1:0]        fifo_occ;
  logic              fifo_push, fifo_pop;
  logic              bypass, issue, hs;
  logic [CNT_W-1:0]  req_count;

  stream_fifo2 #(.DATA_W(DATA_W)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (fifo_push),
    .push_data  (mem_data),
    .pop        (fifo_pop),
    .head_data  (fifo_head),
    .head_valid (fifo_valid),
    .occupancy  (fifo_occ)
  );

  assign req_count = sat_count(count);

  // Issue gate: budget counts both buffered words and the one still in the memory.
  assign issue = (state_q == S_RUN) && (issue_left_q != '0) &&
                 ((fifo_occ + {1'b0, inflight_q}) < 2'd2);

  // Empty buffer + word arriving: present the memory output directly.
  assign bypass    = inflight_q && !fifo_valid;
  assign out_valid = fifo_valid || inflight_q;
  assign out_data  = bypass ? mem_data : fifo_head;
  assign hs        = out_valid && out_ready;
  assign fifo_pop  = fifo_valid && out_ready;
  // Only a bypassed word that is accepted immediately skips the buffer.
  assign fifo_push = inflight_q && !(bypass && out_ready);

  assign mem_addr = issue ? rd_ptr_q : last_addr_q;
  assign mem_wr   = 1'b0;
  assign busy     = (state_q == S_RUN);
  assign done     = (state_q == S_FIN);

  always_comb begin
    state_d      = state_q;
    rd_ptr_d     = rd_ptr_q;
    issue_left_d = issue_left_q;
    out_left_d   = out_left_q;
    inflight_d   = issue;
    last_addr_d  = mem_addr;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          rd_ptr_d     = base_addr;
          issue_left_d = req_count;
          out_left_d   = req_count;
          state_d      = (req_count == '0) ? S_FIN : S_RUN;
        end
      end
      S_RUN: begin
        if (issue) begin
          rd_ptr_d     = rd_ptr_q + ADDR_W'(1);
          issue_left_d = issue_left_q - CNT_W'(1);
        end
        if (hs) begin
          out_left_d = out_left_q - CNT_W'(1);
          if (out_left_q == CNT_W'(1)) state_d = S_FIN;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      rd_ptr_q     <= '0;
      issue_left_q <= '0;
      out_left_q   <= '0;
      inflight_q   <= 1'b0;
      last_addr_q  <= '0;
    end else begin
      state_q      <= state_d;
      rd_ptr_q     <= rd_ptr_d;
      issue_left_q <= issue_left_d;
      out_left_q   <= out_left_d;
      inflight_q   <= inflight_d;
      last_addr_q  <= last_addr_d;
    end
  end

endmodule

// File: tb/tb_memory_stream_reader.sv
// Bench for memory_stream_reader: behavioural 16x8 memory with registered read,
// a negedge monitor, a table of directed bursts, two hand sequences (restart
// while busy, reset mid-burst) and randomized bursts with random backpressure.
module tb_memory_stream_reader;
  import memory_stream_reader_pkg::*;

  logic       clk = 1'b0;
  logic       rst, start, mem_wr, out_valid, out_ready, busy, done;
  logic [3:0] base_addr, mem_addr;
  logic [4:0] count;
  logic [7:0] mem_data, out_data;

  always #5 clk = ~clk;

  memory_stream_reader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .count     (count),
    .mem_addr  (mem_addr),
    .mem_wr    (mem_wr),
    .mem_data  (mem_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
  );

  logic [7:0] mem [16];
  always @(posedge clk) mem_data <= mem[mem_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor state
  logic [7:0] hs_data[$];
  int         hs_cyc[$];
  int         done_cyc[$];
  int         addr_seq[$];
  int         max_ahead = 0, stall_err = 0, busy_done_err = 0, wr_err = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;

  always @(negedge clk) begin
    if (!rst) begin
      if (prev_stall && (out_valid !== 1'b1 || out_data !== prev_data)) stall_err++;
      if (busy && (addr_seq.size() == 0 || addr_seq[addr_seq.size()-1] != int'(mem_addr)))
        addr_seq.push_back(int'(mem_addr));
      if (addr_seq.size() - hs_data.size() > max_ahead)
        max_ahead = addr_seq.size() - hs_data.size();
      if (out_valid && out_ready) begin
        hs_data.push_back(out_data);
        hs_cyc.push_back(cyc);
      end
      if (done) begin
        done_cyc.push_back(cyc);
        if (busy) busy_done_err++;
      end
      if (mem_wr !== 1'b0) wr_err++;
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  int total = 0, passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic clear_mon();
    hs_data.delete(); hs_cyc.delete(); done_cyc.delete(); addr_seq.delete();
    max_ahead = 0; stall_err = 0; busy_done_err = 0;
  endtask

  task automatic fill_ramp();
    for (int a = 0; a < 16; a++) mem[a] = 8'h10 + 8'(a);
  endtask

  // mode 0: ready always 1; 1: ready toggles each clk; 2: random ready.
  task automatic run_burst(input int base, input int cnt, input int mode, input bit restart,
                           output logic [7:0] first_d, output logic [7:0] last_d);
    int n, k, waited, addr0, exp_done;
    logic b1, tog;
    logic [7:0] exp_q[$];
    n = (cnt > 16) ? 16 : cnt;
    for (int i = 0; i < n; i++) exp_q.push_back(mem[(base + i) % 16]);
    @(posedge clk); #1;
    clear_mon();
    addr0     = int'(mem_addr);
    start     = 1'b1;
    base_addr = 4'(base);
    count     = 5'(cnt);
    tog       = 1'b1;
    out_ready = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
    k = cyc;
    waited = 0;
    b1 = 1'b0;
    while (done_cyc.size() == 0 && waited < 120) begin
      @(posedge clk); #1;
      waited++;
      if (waited == 1) b1 = busy;
      if (restart && waited == 2) begin
        start = 1'b1; base_addr = 4'd9; count = 5'd3;
      end else begin
        start = 1'b0; base_addr = 4'($urandom); count = 5'($urandom);
      end
      if (mode == 1) begin tog = !tog; out_ready = tog; end
      else if (mode == 2) out_ready = 1'($urandom_range(0, 1));
      else out_ready = 1'b1;
    end
    repeat (2) begin @(posedge clk); #1; start = 1'b0; out_ready = 1'b1; end
    @(negedge clk);

    chk("timeout", waited < 120, 1);
    chk("busy_start", b1, n > 0);
    chk("words", hs_data.size(), n);
    for (int i = 0; i < n && i < hs_data.size(); i++) chk("data", hs_data[i], exp_q[i]);
    chk("done_pulses", done_cyc.size(), 1);
    exp_done = (hs_cyc.size() == 0) ? k + 1 : hs_cyc[hs_cyc.size()-1] + 1;
    if (done_cyc.size() > 0) chk("done_cycle", done_cyc[0], exp_done);
    if (mode == 0 && n > 0 && hs_cyc.size() == n) begin
      chk("first_latency", hs_cyc[0], k + 2);
      chk("last_latency", hs_cyc[n-1], k + n + 1);
    end
    chk("stall_stable", stall_err, 0);
    chk("ahead_le_2", max_ahead <= 2, 1);
    chk("addr_count", addr_seq.size(), n);
    for (int i = 0; i < n && i < addr_seq.size(); i++) chk("addr", addr_seq[i], (base + i) % 16);
    if (n == 0) chk("addr_hold", mem_addr, addr0);
    chk("busy_at_done", busy_done_err, 0);
    chk("mem_wr", wr_err, 0);
    first_d = (hs_data.size() > 0) ? hs_data[0] : 8'h00;
    last_d  = (hs_data.size() > 0) ? hs_data[hs_data.size()-1] : 8'h00;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wr"}, mem_wr, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  typedef struct {
    int         base;
    int         cnt;
    int         mode;
    bit         restart;
    int         exp_n;
    logic [7:0] exp_first;
    logic [7:0] exp_last;
  } vec_t;

  initial begin
    vec_t       vecs[9];
    logic [7:0] f, l;
    int         waited;

    vecs[0] = '{0,  3, 0, 0, 3,  8'h10, 8'h12};
    vecs[1] = '{14, 4, 0, 0, 4,  8'h1E, 8'h11};
    vecs[2] = '{2,  5, 1, 0, 5,  8'h12, 8'h16};
    vecs[3] = '{0,  0, 0, 0, 0,  8'h00, 8'h00};
    vecs[4] = '{4,  6, 0, 1, 6,  8'h14, 8'h19};
    vecs[5] = '{5, 16, 0, 0, 16, 8'h15, 8'h14};
    vecs[6] = '{7, 20, 0, 0, 16, 8'h17, 8'h16};
    vecs[7] = '{3,  1, 1, 0, 1,  8'h13, 8'h13};
    vecs[8] = '{15, 2, 2, 0, 2,  8'h1F, 8'h10};

    fill_ramp();
    rst = 1'b1; start = 1'b0; out_ready = 1'b0; base_addr = '0; count = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    foreach (vecs[i]) begin
      run_burst(vecs[i].base, vecs[i].cnt, vecs[i].mode, vecs[i].restart, f, l);
      chk("tbl_words", hs_data.size(), vecs[i].exp_n);
      if (vecs[i].exp_n > 0) begin
        chk("tbl_first", f, vecs[i].exp_first);
        chk("tbl_last", l, vecs[i].exp_last);
      end
    end

    // Reset after the second accepted word of a 6-word burst.
    @(posedge clk); #1;
    clear_mon();
    start = 1'b1; base_addr = 4'd0; count = 5'd6; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    waited = 0;
    while (hs_data.size() < 2 && waited < 20) begin @(posedge clk); #1; waited++; end
    chk("rst_wait", waited < 20, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk_reset_outputs("midrst");
    done_cyc.delete();
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("midrst_no_done", done_cyc.size(), 0);
    run_burst(0, 1, 0, 0, f, l);
    chk("post_rst_word", f, 8'h10);

    // Randomized bursts over random memory contents and random backpressure.
    for (int r = 0; r < 20; r++) begin
      for (int a = 0; a < 16; a++) mem[a] = 8'($urandom);
      run_burst(int'($urandom_range(0, 15)), int'($urandom_range(0, 18)), 2, 0, f, l);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
